// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B, LSB first, single borrow flop
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pload,
    input  logic         enable,
    input  logic [W-1:0] adata,
    input  logic [W-1:0] bdata,
    output logic [W-1:0] pout,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  sr;
    logic          br;
    logic [CW-1:0] cnt;
    logic          d;
    logic          br_next;
    logic          step_en;
    logic          last;

    always_comb begin
        d          = sa[0] ^ sb[0] ^ br;
        br_next    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        step_en    = (state == RUN) && enable && !pload;
        last       = (cnt == CW'(W - 1));
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            RUN: begin
                busy = 1'b1;
                if (step_en && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // a load restarts from any state, aborting a run without a done pulse
        if (pload) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            pout  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_next;
            if (pload) begin
                sa  <= adata;
                sb  <= bdata;
                sr  <= '0;
                br  <= 1'b0;
                cnt <= '0;
            end else if (step_en) begin
                sa  <= {1'b0, sa[W-1:1]};
                sb  <= {1'b0, sb[W-1:1]};
                sr  <= {d, sr[W-1:1]};
                br  <= br_next;
                cnt <= cnt + CW'(1);
                if (last) begin
                    pout <= {d, sr[W-1:1]};
                    bout <= br_next;
                end
            end
        end
    end

endmodule
